// File: rtl/w_debounce_pkg.sv
// Shared state encodings and a debug decode for the w_debounce input conditioner.
package w_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO      = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_HI      = 2'b11,
    ST_WAIT_LO = 2'b10
  } st_e;

  // Single-character state tag for trace printing in benches/debug viewers.
  function automatic byte st_char(input st_e st);
    case (st)
      ST_LO:      st_char = "L";
      ST_WAIT_HI: st_char = "R";
      ST_HI:      st_char = "H";
      ST_WAIT_LO: st_char = "F";
      default:    st_char = "?";
    endcase
  endfunction

endpackage

// File: rtl/w_debounce_sync2.sv
// Two-flop synchroniser for a raw asynchronous level; reusable for any raw input.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/w_debounce.sv
// Debounces a raw switch level into a clean registered w plus one-cycle edge strobes.
module w_debounce
  import w_debounce_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic w,
  output logic w_rise,
  output logic w_fall
);

  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("w_debounce: DEBOUNCE_CYC out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s;
  st_e              state;
  logic [CNT_W-1:0] cnt;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (s)
  );

  // s is checked before the count in WAIT states so a toggle on the
  // completing edge aborts rather than commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_LO;
      cnt    <= '0;
      w      <= 1'b0;
      w_rise <= 1'b0;
      w_fall <= 1'b0;
    end else begin
      w_rise <= 1'b0;
      w_fall <= 1'b0;
      case (state)
        ST_LO: begin
          if (s) begin
            state <= ST_WAIT_HI;
            cnt   <= '0;
          end
        end
        ST_WAIT_HI: begin
          if (!s) begin
            state <= ST_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_HI;
            w      <= 1'b1;
            w_rise <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HI: begin
          if (!s) begin
            state <= ST_WAIT_LO;
            cnt   <= '0;
          end
        end
        ST_WAIT_LO: begin
          if (s) begin
            state <= ST_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_LO;
            w      <= 1'b0;
            w_fall <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_LO;
          cnt   <= '0;
          w     <= 1'b0;
        end
      endcase
    end
  end

endmodule
